gray_code_source: RTL and testbench

Sequential Gray-code generator feeding the Gray-to-binary converter stage. Holds a binary count and steps it up or down at a programmable rate. Each count is presented as a registered Gray code word on a valid/ready output, and the count stalls under back-pressure. It exists so the downstream converter sees a realistic, rate-controlled, single-bit-change code stream.

---
 rtl/gray_pkg.sv | 17 +
 rtl/gray_prescaler.sv | 38 +++
 rtl/gray_code_source.sv | 124 ++++++++++++
 tb/tb_gray_code_source.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code source and its verification model.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2
  } gray_state_e;

  // Binary to reflected Gray code; callers narrow the result to their own width.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_prescaler.sv
// Rate counter: counts 0..PRESCALE-1 while enabled, flags terminal count.
module gray_prescaler #(
  parameter int unsigned PRESCALE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q == CW'(PRESCALE - 1));

endmodule

// File: rtl/gray_code_source.sv
// Rate-controlled Gray-code stream with valid/ready back-pressure.
module gray_code_source
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] G,
  output logic             g_valid,
  input  logic             g_ready,
  output logic             wrap,
  output logic             busy
);

  gray_state_e      state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             g_valid_q, g_valid_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;
  logic             stop_pend_q, stop_pend_d;
  logic             hs_c;
  logic             presc_tc_c;
  logic             presc_clr_c;
  logic             presc_en_c;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return WIDTH'(bin2gray(GRAY_MAX_W'(b)));
  endfunction

  assign hs_c        = g_valid_q && g_ready;
  assign presc_en_c  = (state_q == WAIT);
  assign presc_clr_c = (state_q != WAIT) || presc_tc_c;

  gray_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (presc_clr_c),
    .en   (presc_en_c),
    .tc_c (presc_tc_c)
  );

  // Next-state, count and output register inputs.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    g_d         = g_q;
    g_valid_d   = g_valid_q;
    wrap_d      = 1'b0;
    stop_pend_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          bin_d = load_val;
        end
        if (!stop && start) begin
          state_d   = EMIT;
          g_d       = to_gray(load ? load_val : bin_q);
          g_valid_d = 1'b1;
        end
      end
      EMIT: begin
        if (hs_c) begin
          bin_d     = dir ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
          wrap_d    = dir ? (bin_q == '0) : (bin_q == '1);
          g_valid_d = 1'b0;
          state_d   = (stop || stop_pend_q) ? IDLE : WAIT;
        end else begin
          // A stop during a stall is held until the word is accepted.
          stop_pend_d = stop_pend_q | stop;
        end
      end
      WAIT: begin
        if (stop) begin
          state_d = IDLE;
        end else if (presc_tc_c) begin
          state_d   = EMIT;
          g_d       = to_gray(bin_q);
          g_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      g_q         <= '0;
      g_valid_q   <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      g_q         <= g_d;
      g_valid_q   <= g_valid_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign G       = g_q;
  assign g_valid = g_valid_q;
  assign wrap    = wrap_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_gray_code_source.sv
// Self-checking bench for gray_code_source (WIDTH=4, PRESCALE=2).
module tb_gray_code_source;

  localparam int unsigned W = 4;
  localparam int unsigned P = 2;
  localparam int          M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] G;
  logic         g_valid;
  logic         g_ready;
  logic         wrap;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Transaction-level reference model
  logic         m_busy, m_valid, m_wrap, m_pend, have_prev;
  int           m_bin, m_gap;
  logic [W-1:0] m_g, prev_word;
  logic [W-1:0] g_hold;

  gray_code_source #(
    .WIDTH   (W),
    .PRESCALE(P)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .dir     (dir),
    .load    (load),
    .load_val(load_val),
    .G       (G),
    .g_valid (g_valid),
    .g_ready (g_ready),
    .wrap    (wrap),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gw(input int b);
    int g;
    g = (b ^ (b >> 1)) % M;
    return W'(g);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_valid   = 1'b0;
    m_wrap    = 1'b0;
    m_pend    = 1'b0;
    have_prev = 1'b0;
    m_bin     = 0;
    m_gap     = 0;
    m_g       = '0;
    prev_word = '0;
  endtask

  task automatic zero_inputs();
    start    = 1'b0;
    stop     = 1'b0;
    dir      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    g_ready  = 1'b0;
  endtask

  // Check current outputs, drive one cycle of inputs, advance the model.
  task automatic model_cycle(input logic rdy, input logic d, input logic stp,
                             input logic st, input logic ld, input int lv);
    chk("g_valid", 32'(g_valid), 32'(m_valid));
    chk("G",       32'(G),       32'(m_g));
    chk("busy",    32'(busy),    32'(m_busy));
    chk("wrap",    32'(wrap),    32'(m_wrap));
    g_ready  = rdy;
    dir      = d;
    stop     = stp;
    start    = st;
    load     = ld;
    load_val = W'(lv);
    m_wrap   = 1'b0;
    if (!m_busy) begin
      if (ld) m_bin = lv % M;
      if (st && !stp) begin
        m_busy    = 1'b1;
        m_valid   = 1'b1;
        m_g       = gw(m_bin);
        have_prev = 1'b0;
      end
    end else if (m_valid) begin
      if (rdy) begin
        if (have_prev) chk("one_bit", 32'($countones(prev_word ^ m_g)), 32'd1);
        prev_word = m_g;
        have_prev = 1'b1;
        m_wrap    = d ? (m_bin == 0) : (m_bin == M - 1);
        m_bin     = d ? (m_bin + M - 1) % M : (m_bin + 1) % M;
        m_valid   = 1'b0;
        m_gap     = P;
        if (stp || m_pend) m_busy = 1'b0;
        m_pend    = 1'b0;
      end else begin
        m_pend = m_pend | stp;
      end
    end else begin
      if (stp) begin
        m_busy = 1'b0;
      end else begin
        m_gap--;
        if (m_gap == 0) begin
          m_valid = 1'b1;
          m_g     = gw(m_bin);
        end
      end
    end
    @(negedge clk);
  endtask

  logic [W-1:0] seq5 [4];

  initial begin
    seq5[0] = 4'b0111;
    seq5[1] = 4'b0101;
    seq5[2] = 4'b0100;
    seq5[3] = 4'b1100;

    // Power-on reset
    rst_n = 1'b0;
    zero_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_G",       32'(G),       32'd0);
    chk("rst_g_valid", 32'(g_valid), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_wrap",    32'(wrap),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while waiting between codes
    model_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5);
    model_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    model_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("pre_rst_G", 32'(G), 32'(4'b0111));
    rst_n = 1'b0;
    zero_inputs();
    #1;
    chk("midrst_G",       32'(G),       32'd0);
    chk("midrst_g_valid", 32'(g_valid), 32'd0);
    chk("midrst_busy",    32'(busy),    32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("first_after_rst", 32'(G), 32'd0);
    model_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    model_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Load 5, count up, one code every PRESCALE+1 cycles
    model_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5);
    chk("seq5_0", 32'(G), 32'(seq5[0]));
    for (int k = 1; k < 4; k++) begin
      for (int c = 0; c < 3; c++) model_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      chk($sformatf("seq5_%0d", k), 32'(G), 32'(seq5[k]));
    end
    model_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    model_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("seq5_idle_busy", 32'(busy), 32'd0);

    // Up rollover 15 -> 0
    model_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 15);
    chk("up_G15", 32'(G), 32'(4'b1000));
    model_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("up_wrap", 32'(wrap), 32'd1);
    model_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("up_wrap_clr", 32'(wrap), 32'd0);
    model_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("up_G0", 32'(G), 32'd0);
    model_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    model_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Down rollover 0 -> 15 -> 14
    model_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    chk("dn_G0", 32'(G), 32'd0);
    model_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("dn_wrap", 32'(wrap), 32'd1);
    model_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    model_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("dn_G15", 32'(G), 32'(4'b1000));
    for (int c = 0; c < 3; c++) model_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("dn_G14", 32'(G), 32'(4'b1001));
    model_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    model_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Back-pressure with a stop pulse during the stall
    model_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6);
    g_hold = G;
    for (int i = 0; i < 10; i++) model_cycle(1'b0, 1'b0, (i == 3), 1'b0, 1'b0, 0);
    chk("bp_G_stable", 32'(G), 32'(g_hold));
    chk("bp_valid",    32'(g_valid), 32'd1);
    chk("bp_busy",     32'(busy), 32'd1);
    model_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    model_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("bp_advanced", 32'(G), 32'(gw(7)));
    model_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    model_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // start and stop together in IDLE
    model_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("ss_busy",  32'(busy),    32'd0);
    chk("ss_valid", 32'(g_valid), 32'd0);

    // load while waiting is ignored
    model_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    model_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    model_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9);
    model_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("ldwait_G", 32'(G), 32'(gw(3)));
    model_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    model_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      model_cycle(($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, M - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
